ppi_mode1_handshake: RTL and testbench



---
 rtl/ppi_pkg.sv | 10 +
 rtl/ppi_sync_edge.sv | 24 ++
 rtl/ppi_mode1_handshake.sv | 96 +++++++++
 tb/tb_ppi_mode1_handshake.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ppi_pkg.sv
// ppi_pkg: shared states, status bit indices and direction constants for the Mode 1 handshake
package ppi_pkg;
  typedef enum logic [2:0] {IDLE, STROBED, FULL, PENDING, ACKED} state_t;
  localparam int ST_INTR = 3;
  localparam int ST_BUF = 2;
  localparam int ST_INTE = 1;
  localparam int ST_OVR = 0;
  localparam logic DIR_IN = 1'b1;
  localparam logic DIR_OUT = 1'b0;
endpackage

// File: rtl/ppi_sync_edge.sv
// ppi_sync_edge: multi-stage synchronizer for an idle-high pin with registered rise/fall pulses
module ppi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end
  assign rise = ~prev & sync[STAGES-1];
  assign fall = prev & ~sync[STAGES-1];
endmodule

// File: rtl/ppi_mode1_handshake.sv
// ppi_mode1_handshake: 8255 Mode 1 strobed I/O handshake for one port; PPI_HS_OVERRUN_EN drops captures while IBF=1 and flags ovr
module ppi_mode1_handshake
  import ppi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             dir,
  input  logic             bus_wr_stb,
  input  logic             bus_rd_stb,
  input  logic [WIDTH-1:0] bus_din,
  output logic [WIDTH-1:0] bus_dout,
  input  logic             inte_wr,
  input  logic             inte_val,
  input  logic             STB_n,
  input  logic             ACK_n,
  input  logic [WIDTH-1:0] port_in,
  output logic [WIDTH-1:0] port_out,
  output logic             port_oe,
  output logic             IBF,
  output logic             OBF_n,
  output logic             INTR,
  output logic [3:0]       status
);
`ifdef PPI_HS_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif
  state_t state;
  logic inte, ovr, stb_rise, stb_fall, ack_rise, ack_fall, dir_chg;
  ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_stb (.clk(CLK), .rst(RST), .d(STB_n), .rise(stb_rise), .fall(stb_fall));
  ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_ack (.clk(CLK), .rst(RST), .d(ACK_n), .rise(ack_rise), .fall(ack_fall));
  assign dir_chg = dir == port_oe;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      inte <= 1'b0;
      ovr <= 1'b0;
      port_oe <= 1'b0;
      IBF <= 1'b0;
      OBF_n <= 1'b1;
      INTR <= 1'b0;
      bus_dout <= '0;
      port_out <= '0;
    end else begin
      port_oe <= ~dir;
      if (inte_wr) inte <= inte_val;
      if (dir_chg) begin
        state <= IDLE;
        IBF <= 1'b0;
        OBF_n <= 1'b1;
        INTR <= 1'b0;
      end else if (dir == DIR_IN) begin
        if (bus_rd_stb) ovr <= 1'b0;
        if (stb_fall) begin
          if (IBF && !bus_rd_stb && OVR_EN) ovr <= 1'b1;
          else bus_dout <= port_in;
          if (bus_rd_stb) INTR <= 1'b0;
          IBF <= 1'b1;
          state <= STROBED;
        end else if (bus_rd_stb && (state == FULL || state == STROBED)) begin
          INTR <= 1'b0;
          IBF <= 1'b0;
          state <= IDLE;
        end else if (stb_rise && state == STROBED) begin
          INTR <= inte;
          state <= FULL;
        end
      end else begin
        if (bus_wr_stb) begin
          port_out <= bus_din;
          OBF_n <= 1'b0;
          INTR <= 1'b0;
          state <= PENDING;
        end else if (ack_fall && state == PENDING) begin
          OBF_n <= 1'b1;
          state <= ACKED;
        end else if (ack_rise && state == ACKED) begin
          INTR <= inte;
          state <= IDLE;
        end
      end
      if (inte_wr && !inte_val) INTR <= 1'b0;
    end
  end
  always_comb begin
    status = '0;
    status[ST_INTR] = INTR;
    status[ST_BUF] = IBF | ~OBF_n;
    status[ST_INTE] = inte;
    status[ST_OVR] = ovr;
  end
endmodule

// File: tb/tb_ppi_mode1_handshake.sv
// tb_ppi_mode1_handshake: directed self-checking bench for the Mode 1 handshake stage
module tb_ppi_mode1_handshake;
  import ppi_pkg::*;
  logic CLK = 1'b0, RST = 1'b1, dir = 1'b1, bus_wr_stb = 1'b0, bus_rd_stb = 1'b0;
  logic inte_wr = 1'b0, inte_val = 1'b0, STB_n = 1'b1, ACK_n = 1'b1;
  logic [7:0] bus_din = '0, port_in = '0, bus_dout, port_out;
  logic port_oe, IBF, OBF_n, INTR;
  logic [3:0] status;
  int n_chk = 0, n_fail = 0;
  ppi_mode1_handshake dut (
    .CLK(CLK), .RST(RST), .dir(dir), .bus_wr_stb(bus_wr_stb), .bus_rd_stb(bus_rd_stb),
    .bus_din(bus_din), .bus_dout(bus_dout), .inte_wr(inte_wr), .inte_val(inte_val),
    .STB_n(STB_n), .ACK_n(ACK_n), .port_in(port_in), .port_out(port_out), .port_oe(port_oe),
    .IBF(IBF), .OBF_n(OBF_n), .INTR(INTR), .status(status)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    @(negedge CLK);
  endtask
  task automatic set_inte(input logic v);
    inte_wr = 1'b1;
    inte_val = v;
    tick(1);
    inte_wr = 1'b0;
  endtask
  task automatic strobe(input logic [7:0] v);
    port_in = v;
    STB_n = 1'b0;
    tick(4);
    STB_n = 1'b1;
    tick(4);
  endtask
  task automatic ack_pulse();
    ACK_n = 1'b0;
    tick(4);
    ACK_n = 1'b1;
    tick(4);
  endtask
  task automatic rd();
    bus_rd_stb = 1'b1;
    tick(1);
    bus_rd_stb = 1'b0;
  endtask
  task automatic wr(input logic [7:0] v);
    bus_din = v;
    bus_wr_stb = 1'b1;
    tick(1);
    bus_wr_stb = 1'b0;
  endtask
  initial begin
    @(negedge CLK);
    check("rst_ibf", IBF, 0);
    check("rst_obf_n", OBF_n, 1);
    check("rst_intr", INTR, 0);
    check("rst_oe", port_oe, 0);
    check("rst_dout", bus_dout, 8'h00);
    check("rst_pout", port_out, 8'h00);
    check("rst_status", status, 4'h0);
    RST = 1'b0;
    tick(1);
    check("oe_in", port_oe, 0);
    set_inte(1'b1);
    check("inte_status", status, 4'b0010);
    port_in = 8'hA5;
    STB_n = 1'b0;
    tick(2);
    check("ibf_early", IBF, 0);
    tick(1);
    check("ibf_3edges", IBF, 1);
    check("capture_a5", bus_dout, 8'hA5);
    tick(1);
    STB_n = 1'b1;
    tick(2);
    check("intr_early", INTR, 0);
    tick(1);
    check("intr_rise", INTR, 1);
    check("status_full", status, 4'hE);
    bus_rd_stb = 1'b1;
    check("dout_pre_rd", bus_dout, 8'hA5);
    tick(1);
    bus_rd_stb = 1'b0;
    check("rd_ibf", IBF, 0);
    check("rd_intr", INTR, 0);
    check("rd_dout", bus_dout, 8'hA5);
    strobe(8'h11);
    strobe(8'h22);
    check("ovr_ibf", IBF, 1);
    check("ovr_intr", INTR, 1);
`ifdef PPI_HS_OVERRUN_EN
    check("ovr_dout", bus_dout, 8'h11);
    check("ovr_flag", status[ST_OVR], 1);
`else
    check("ovr_dout", bus_dout, 8'h22);
    check("ovr_flag", status[ST_OVR], 0);
`endif
    rd();
    check("ovr_clr", status[ST_OVR], 0);
    check("ovr_rd_ibf", IBF, 0);
    strobe(8'h44);
    check("inte_intr_set", INTR, 1);
    set_inte(1'b0);
    check("inte_clr_intr", INTR, 0);
    rd();
    strobe(8'h5A);
    check("noint_ibf", IBF, 1);
    check("noint_intr", INTR, 0);
    check("noint_dout", bus_dout, 8'h5A);
    dir = 1'b0;
    check("oe_hold", port_oe, 0);
    tick(1);
    check("dir_ibf", IBF, 0);
    check("dir_obf_n", OBF_n, 1);
    check("dir_oe", port_oe, 1);
    check("dir_latch", bus_dout, 8'h5A);
    set_inte(1'b1);
    wr(8'h3C);
    check("wr_pout", port_out, 8'h3C);
    check("wr_obf_n", OBF_n, 0);
    check("wr_status", status, 4'b0110);
    ACK_n = 1'b0;
    tick(2);
    check("ack_early", OBF_n, 0);
    tick(1);
    check("ack_fall", OBF_n, 1);
    tick(1);
    ACK_n = 1'b1;
    tick(2);
    check("ack_intr_early", INTR, 0);
    tick(1);
    check("ack_intr", INTR, 1);
    wr(8'h77);
    check("wr2_intr", INTR, 0);
    check("wr2_pout", port_out, 8'h77);
    ACK_n = 1'b0;
    tick(2);
    bus_din = 8'hC3;
    bus_wr_stb = 1'b1;
    tick(1);
    bus_wr_stb = 1'b0;
    check("coll_obf_n", OBF_n, 0);
    check("coll_pout", port_out, 8'hC3);
    tick(1);
    ACK_n = 1'b1;
    tick(4);
    check("coll_hold", OBF_n, 0);
    check("coll_intr", INTR, 0);
    ack_pulse();
    check("coll_ack_obf", OBF_n, 1);
    check("coll_ack_intr", INTR, 1);
    ack_pulse();
    check("idle_ack_obf", OBF_n, 1);
    check("idle_ack_intr", INTR, 1);
    rd();
    check("out_rd_ign", INTR, 1);
    wr(8'h99);
    check("pre_rst_obf", OBF_n, 0);
    #2 RST = 1'b1;
    #1;
    check("arst_obf_n", OBF_n, 1);
    check("arst_pout", port_out, 8'h00);
    check("arst_dout", bus_dout, 8'h00);
    check("arst_oe", port_oe, 0);
    check("arst_status", status, 4'h0);
    @(negedge CLK);
    RST = 1'b0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
